// File: rtl/fifo_pkg.sv
// Shared FIFO sizing helpers and read-mode constants.
package fifo_pkg;

   localparam int unsigned FIFO_STD  = 0;
   localparam int unsigned FIFO_FWFT = 1;

   // Pointer width: enough bits to address DEPTH entries.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Count width: one extra bit so the value DEPTH is representable.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array with one synchronous write port and one asynchronous read port.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [ptr_w(DEPTH)-1:0]   waddr,
   input  logic [WIDTH-1:0]          wdata,
   input  logic [ptr_w(DEPTH)-1:0]   raddr,
   output logic [WIDTH-1:0]          rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact count, threshold flags, error pulses and
// selectable standard / first-word-fall-through read mode.
module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AF_THRESH = DEPTH - 2,
   parameter int unsigned AE_THRESH = 2,
   parameter int unsigned FWFT      = FIFO_STD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [cnt_w(DEPTH)-1:0]  count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned CW = cnt_w(DEPTH);

   // Reject illegal configurations at elaboration.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
      $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
   end
   if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_thresh_chk
      $error("sync_fifo_flags: need AE_THRESH < AF_THRESH <= DEPTH");
   end

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] ram_rdata;
   logic             wr_acc;
   logic             rd_acc;

   // Flags decode straight from the count register so they track it exactly.
   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == CW'(0));
   assign almost_full  = (count >= CW'(AF_THRESH));
   assign almost_empty = (count <= CW'(AE_THRESH));

   // No bypass: a read on empty or a write on full is rejected outright.
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   // Pointers wrap by natural overflow of their power-of-two width.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Occupancy: net change of accepted writes minus accepted reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // One-cycle error pulses for rejected requests; FIFO state is untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end
   end

   if (FWFT == FIFO_FWFT) begin : g_fwft
      // Head word is always presented; rd_en only acknowledges it.
      assign rd_data  = ram_rdata;
      assign rd_valid = !empty;
   end else begin : g_std
      // Registered read: data lands one edge after an accepted rd_en.
      always_ff @(posedge clk) begin
         if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
         end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= ram_rdata;
         end
      end
   end

endmodule
